// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative, write-back, write-allocate cache.
// The controller and the datapath live in this one block. It sits between
// the CPU memory port and the physical-memory (arbiter) port.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_read/mem_write  CPU request, held until mem_resp
//   mem_address         CPU byte address
//   mem_wdata           CPU write word
//   mem_byte_enable     byte lanes written on a CPU write
//   mem_rdata           read word, valid while mem_resp
//   mem_resp            CPU request complete (same cycle on a hit)
//   pmem_read/write     line fill / write-back strobes, held until pmem_resp
//   pmem_address        line-aligned physical address
//   pmem_wdata          write-back line
//   pmem_rdata          fill line, valid with pmem_resp
//   pmem_resp           physical transfer complete
//   flush               level request to write back every dirty line
//   flush_done          one-cycle pulse when the flush has finished
module cache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_W-1:0]       mem_address,
    input  logic [WORD_W-1:0]       mem_wdata,
    input  logic [WORD_W/8-1:0]     mem_byte_enable,
    output logic [WORD_W-1:0]       mem_rdata,
    output logic                    mem_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic [ADDR_W-1:0]       pmem_address,
    output logic [LINE_BYTES*8-1:0] pmem_wdata,
    input  logic [LINE_BYTES*8-1:0] pmem_rdata,
    input  logic                    pmem_resp,
    input  logic                    flush,
    output logic                    flush_done
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int BE_W   = WORD_W / 8;
    localparam int BOFF_W = $clog2(BE_W);
    localparam int WSEL_W = OFF_W - BOFF_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int FCNT_W = IDX_W + WAY_W;

    typedef enum logic [2:0] {
        S_CHECK,
        S_WRITEBACK,
        S_FILL,
        S_FLUSH_SCAN,
        S_FLUSH_WB,
        S_FLUSH_DONE
    } state_t;

    state_t              r_state;
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [LINE_W-1:0]   r_data  [SETS][WAYS];
    logic [WAY_W-1:0]    r_vptr  [SETS];
    logic [WAY_W-1:0]    r_victim;
    logic [FCNT_W-1:0]   r_fcnt;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic                r_flush_done;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [WSEL_W-1:0]   w_wsel;
    logic                w_req;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic                w_has_inv;
    logic [WAY_W-1:0]    w_inv_way;
    logic [WAY_W-1:0]    w_victim;
    logic [LINE_W-1:0]   w_hit_line;
    logic [WORD_W-1:0]   w_rword;
    logic [WORD_W-1:0]   w_wword;
    logic                w_hit_we;
    logic                w_fill_we;
    logic [IDX_W-1:0]    w_fidx;
    logic [WAY_W-1:0]    w_fway;
    logic                w_flast;
    logic [ADDR_W-1:0]   w_pmem_addr;
    logic [LINE_W-1:0]   w_pmem_wdata;
    logic                w_unused_ofs;

    assign w_tag  = mem_address[ADDR_W-1 -: TAG_W];
    assign w_idx  = mem_address[OFF_W +: IDX_W];
    assign w_wsel = mem_address[BOFF_W +: WSEL_W];
    assign w_req  = mem_read | mem_write;
    // Byte offset inside a word is irrelevant to a word-wide port.
    assign w_unused_ofs = ^mem_address[OFF_W-1:0];

    // Flush counter walks set-major: entry = set * WAYS + way.
    assign w_fidx  = r_fcnt[FCNT_W-1 -: IDX_W];
    assign w_fway  = r_fcnt[WAY_W-1:0];
    assign w_flast = (r_fcnt == FCNT_W'(SETS * WAYS - 1));

    // Tag match and victim choice (lowest invalid way, else the set pointer).
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][WAY_W'(w)] && (r_tag[w_idx][WAY_W'(w)] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!w_has_inv && !r_valid[w_idx][WAY_W'(w)]) begin
                w_has_inv = 1'b1;
                w_inv_way = WAY_W'(w);
            end
        end
        w_victim = w_has_inv ? w_inv_way : r_vptr[w_idx];
    end

    assign w_hit_line = r_data[w_idx][w_hit_way];
    assign w_rword    = w_hit_line[w_wsel*WORD_W +: WORD_W];

    always_comb begin
        w_wword = w_rword;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (mem_byte_enable[b]) begin
                w_wword[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    assign mem_resp  = (r_state == S_CHECK) && w_req && w_hit;
    assign mem_rdata = w_rword;
    assign w_hit_we  = mem_resp && mem_write;
    assign w_fill_we = (r_state == S_FILL) && pmem_resp;

    always_comb begin
        w_pmem_addr  = '0;
        w_pmem_wdata = '0;
        case (r_state)
            S_WRITEBACK: begin
                w_pmem_addr  = {r_tag[w_idx][r_victim], w_idx, {OFF_W{1'b0}}};
                w_pmem_wdata = r_data[w_idx][r_victim];
            end
            S_FILL: begin
                w_pmem_addr  = {w_tag, w_idx, {OFF_W{1'b0}}};
            end
            S_FLUSH_WB: begin
                w_pmem_addr  = {r_tag[w_fidx][w_fway], w_fidx, {OFF_W{1'b0}}};
                w_pmem_wdata = r_data[w_fidx][w_fway];
            end
            default: ;
        endcase
    end

    assign pmem_address = w_pmem_addr;
    assign pmem_wdata   = w_pmem_wdata;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign flush_done   = r_flush_done;

    // Line and tag storage need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_idx][r_victim] <= pmem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end else if (w_hit_we) begin
            r_data[w_idx][w_hit_way][w_wsel*WORD_W +: WORD_W] <= w_wword;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CHECK;
            r_valid      <= '{default: '0};
            r_dirty      <= '{default: '0};
            r_vptr       <= '{default: '0};
            r_victim     <= '0;
            r_fcnt       <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_CHECK: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (mem_write) begin
                                r_dirty[w_idx][w_hit_way] <= 1'b1;
                            end
                        end else begin
                            r_victim <= w_victim;
                            if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                                r_state      <= S_WRITEBACK;
                                r_pmem_write <= 1'b1;
                            end else begin
                                r_state     <= S_FILL;
                                r_pmem_read <= 1'b1;
                            end
                        end
                    end else if (flush) begin
                        r_state <= S_FLUSH_SCAN;
                        r_fcnt  <= '0;
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp) begin
                        r_state      <= S_FILL;
                        r_pmem_write <= 1'b0;
                        r_pmem_read  <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (pmem_resp) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_vptr[w_idx]            <= r_vptr[w_idx] + 1'b1;
                        r_pmem_read              <= 1'b0;
                        r_state                  <= S_CHECK;
                    end
                end
                S_FLUSH_SCAN: begin
                    if (r_valid[w_fidx][w_fway] && r_dirty[w_fidx][w_fway]) begin
                        r_state      <= S_FLUSH_WB;
                        r_pmem_write <= 1'b1;
                    end else if (w_flast) begin
                        r_state      <= S_FLUSH_DONE;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                S_FLUSH_WB: begin
                    if (pmem_resp) begin
                        r_dirty[w_fidx][w_fway] <= 1'b0;
                        r_pmem_write            <= 1'b0;
                        // The last entry has no successor to scan.
                        if (w_flast) begin
                            r_state      <= S_FLUSH_DONE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_fcnt  <= r_fcnt + 1'b1;
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                S_FLUSH_DONE: begin
                    r_fcnt  <= '0;
                    r_state <= S_CHECK;
                end
                default: r_state <= S_CHECK;
            endcase
        end
    end
endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-back, write-allocate cache (controller and datapath in one block). It is the next generation of our 2-way L1 cache. It sits between the CPU memory port and the arbiter/physical-memory port. It adds configurable ways, sets and line size, synchronous invalidation on reset, deterministic per-set replacement, and a whole-cache flush command.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, ≥2
- SETS, 8, number of sets; power of two
- LINE_BYTES, 16, bytes per line; power of two, ≥ WORD_W/8
- ADDR_W, 16, byte-address width
- WORD_W, 16, CPU word width; multiple of 8

Ports:
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_address  in  ADDR_W  CPU byte address
- mem_wdata  in  WORD_W  write data
- mem_byte_enable  in  WORD_W/8  byte lanes to write
- mem_rdata  out  WORD_W  read data; valid while mem_resp
- mem_resp  out  1  request complete
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line write-back request; held until pmem_resp
- pmem_address  out  ADDR_W  line-aligned address (offset bits zero)
- pmem_wdata  out  LINE_BYTES*8  write-back line
- pmem_rdata  in  LINE_BYTES*8  fill line; valid with pmem_resp
- pmem_resp  in  1  physical-memory transfer complete
- flush  in  1  level request to write back all dirty lines
- flush_done  out  1  one-cycle pulse when the flush completes

## Operation
- Address split: offset = log2(LINE_BYTES) LSBs; index = next log2(SETS) bits; tag = remaining bits. Word select = offset bits above log2(WORD_W/8).
- Per set and way: valid bit, dirty bit, tag, line. Per set: victim pointer of log2(WAYS) bits.
- Tag and data reads are combinational. Hit = some way is valid with a matching tag. At most one way hits.
- States: CHECK (idle), WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- CHECK, hit:
  - mem_resp=1 in the same cycle.
  - Read: mem_rdata = selected word.
  - Write: enabled bytes merge into the word and dirty is set on the clock edge.
- CHECK, miss:
  - Victim = lowest-index invalid way; if no way is invalid, victim = the set's victim pointer.
  - Victim valid and dirty → WRITEBACK; otherwise → FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address = {victim tag, index, 0}, pmem_wdata = victim line.
  - On pmem_resp → FILL.
- FILL:
  - pmem_read=1, pmem_address = {request tag, index, 0}.
  - On pmem_resp: write line and tag, set valid, clear dirty, advance the set's victim pointer (mod WAYS), → CHECK.
  - The request then hits in CHECK.
- Flush:
  - Accepted in CHECK only when flush=1 and no request is pending. A pending request has priority.
  - FLUSH_SCAN walks a set/way counter from 0 to SETS*WAYS-1, one entry per cycle.
  - A valid, dirty entry → FLUSH_WB. FLUSH_WB writes the entry back like WRITEBACK; on pmem_resp it clears dirty and returns to FLUSH_SCAN at the next entry.
  - After the last entry → FLUSH_DONE, which pulses flush_done for one cycle, then → CHECK.
  - Valid bits and tags are retained.
- Requests arriving during a flush stall (mem_resp=0) until the cache is back in CHECK.
- pmem_read and pmem_write are never both high.

## Timing
- Reset:
  - All valid and dirty bits, victim pointers and the flush counter go to 0; state = CHECK.
  - mem_resp, pmem_read, pmem_write and flush_done are 0 in the cycle after reset is sampled.
  - mem_rdata, pmem_address and pmem_wdata are don't-care while their strobes are low.
- Reset mid-transfer (WRITEBACK, FILL or flush): the transfer is abandoned and strobes drop in the next cycle; the late pmem_resp is ignored.
- Hit latency: 0 cycles (mem_resp in the first CHECK cycle in which the request is seen).
- Clean miss: mem_resp in the cycle after the FILL pmem_resp cycle.
- Dirty miss: the WRITEBACK and FILL handshakes are added back to back.
- Clean flush: SETS*WAYS FLUSH_SCAN cycles, then one FLUSH_DONE cycle.
- The requester deasserts mem_read/mem_write in the cycle after mem_resp. A request still high then is treated as a new request.

## Test plan
(Defaults: tag = [15:7], index = [6:4], word = [3:1].)
1. After reset, read 0x0102 → pmem_read with pmem_address 0x0100; return a line with word1=0xBEEF → mem_resp, mem_rdata=0xBEEF. Re-read 0x0102 → mem_resp in the same cycle with no pmem activity.
2. Write 0x12AB, byte_enable 2'b01, to 0x0102 → 0-cycle mem_resp. A following read returns 0xBEAB.
3. Fill 0x0180 (set 0, way 1), then read 0x0200 → pmem_write to 0x0100 carrying word1=0xBEAB, then pmem_read of 0x0200. Way 0 is replaced (pointer wrapped to 0).
4. With exactly one dirty line, pulse flush → exactly one pmem_write, then flush_done. An immediate second flush → zero pmem_write; flush_done exactly SETS*WAYS+1 cycles after acceptance.
5. Assert reset during FILL → pmem_read low next cycle. A later read of the same address misses again.
6. Assert flush and mem_read together in CHECK → the read completes first, then the flush runs.
